imm_decode_stage: RTL and testbench

- Decode-stage immediate generator and ID/EX immediate latch for the pipelined core.
- Classifies the 16-bit instruction opcode into an immediate field location and signedness.
- Drives an internal `extender` instance with that field selection and signedness.
- Registers the extended immediate into the ID/EX boundary, honouring pipeline stall and flush from the hazard unit.

---
 rtl/imm_decode_stage_if.sv | 36 +++
 rtl/imm_decode_stage.sv | 144 ++++++++++++++
 tb/tb_imm_decode_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage_if
// Description : Bundle between the IF/ID latch, the hazard unit and the
//               ID/EX immediate latch.
//               - in_instr and in_valid come from the IF/ID latch.
//               - stall and flush come from the hazard unit.
//               - out_* are the registered ID/EX immediate fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_decode_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_instr;
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] out_imm;
    logic [1:0]       out_imm_loc;
    logic             out_signed;
    logic             out_valid;
    logic             out_illegal;

    // Upstream side: the instruction source and the hazard unit.
    modport master (
        output in_instr, in_valid, stall, flush,
        input  out_imm, out_imm_loc, out_signed, out_valid, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_instr, in_valid, stall, flush,
        output out_imm, out_imm_loc, out_signed, out_valid, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage (with helper module extender)
// Description : Decode-stage immediate generator and ID/EX immediate latch.
//               - Classifies the opcode into an immediate field and a
//                 signedness.
//               - Extends the selected field to 16 bits.
//               - Registers the result, honouring stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================

// Extends imm5 [4:0], imm8 [7:0] or imm11 [10:0] to 16 bits.
// Location 11 yields zero.
module extender (
    input  wire logic [10:0] i_field,
    input  wire logic [1:0]  i_loc,
    input  wire logic        i_signed,
    output logic      [15:0] o_imm
);
    // Sign bit is masked by i_signed so one concatenation serves both modes.
    always_comb begin
        o_imm = 16'h0000;
        case (i_loc)
            2'b00:   o_imm = {{11{i_signed & i_field[4]}},  i_field[4:0]};
            2'b01:   o_imm = {{8{i_signed & i_field[7]}},   i_field[7:0]};
            2'b10:   o_imm = {{5{i_signed & i_field[10]}},  i_field[10:0]};
            default: o_imm = 16'h0000;
        endcase
    end
endmodule

module imm_decode_stage #(
    parameter int WIDTH = 16    // only 16 is supported
) (
    input  wire logic         clk,
    input  wire logic         rst,
    imm_decode_stage_if.slave bus
);
    localparam logic [1:0] c_LOC_IMM5  = 2'b00;
    localparam logic [1:0] c_LOC_IMM8  = 2'b01;
    localparam logic [1:0] c_LOC_IMM11 = 2'b10;
    localparam logic [1:0] c_LOC_NONE  = 2'b11;

    logic [4:0]       w_opcode;
    logic [1:0]       w_loc;
    logic             w_signed;
    logic             w_illegal;
    logic [15:0]      w_extImm;

    logic [WIDTH-1:0] r_imm;
    logic [1:0]       r_immLoc;
    logic             r_signed;
    logic             r_valid;
    logic             r_illegal;

    assign w_opcode = bus.in_instr[WIDTH-1 -: 5];

    // Opcode decode table: field location, signedness and legality.
    // No-immediate opcodes are HALT, NOP and the R-format group
    // (11001 through 11111); only 00010 and 00011 are undefined.
    always_comb begin
        w_loc     = c_LOC_NONE;
        w_signed  = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            5'b01000, 5'b01001: begin                       // ADDI, SUBI
                w_loc    = c_LOC_IMM5;
                w_signed = 1'b1;
            end
            5'b01010, 5'b01011,                             // XORI, ANDNI
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin   // shifts/rotates
                w_loc    = c_LOC_IMM5;
                w_signed = 1'b0;
            end
            5'b10000, 5'b10001, 5'b10011: begin             // ST, LD, STU
                w_loc    = c_LOC_IMM5;
                w_signed = 1'b1;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111,         // branches
            5'b11000,                                       // LBI
            5'b00101, 5'b00111: begin                       // JR, JALR
                w_loc    = c_LOC_IMM8;
                w_signed = 1'b1;
            end
            5'b10010: begin                                 // SLBI
                w_loc    = c_LOC_IMM8;
                w_signed = 1'b0;
            end
            5'b00100, 5'b00110: begin                       // J, JAL
                w_loc    = c_LOC_IMM11;
                w_signed = 1'b1;
            end
            5'b00000, 5'b00001,                             // HALT, NOP
            5'b11001, 5'b11010, 5'b11011,                   // R-format
            5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
                w_loc    = c_LOC_NONE;
                w_signed = 1'b0;
            end
            default: begin
                w_loc     = c_LOC_NONE;
                w_signed  = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    extender u_extender (
        .i_field  (bus.in_instr[10:0]),
        .i_loc    (w_loc),
        .i_signed (w_signed),
        .o_imm    (w_extImm)
    );

    // ID/EX latch: reset/flush clear, stall holds, otherwise load (bubble -> cleared fields).
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_imm     <= '0;
            r_immLoc  <= c_LOC_NONE;
            r_signed  <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                r_imm     <= w_extImm;
                r_immLoc  <= w_loc;
                r_signed  <= w_signed;
                r_illegal <= w_illegal;
            end else begin
                r_imm     <= '0;
                r_immLoc  <= c_LOC_NONE;
                r_signed  <= 1'b0;
                r_illegal <= 1'b0;
            end
            r_valid <= bus.in_valid;
        end
    end

    assign bus.out_imm     = r_imm;
    assign bus.out_imm_loc = r_immLoc;
    assign bus.out_signed  = r_signed;
    assign bus.out_valid   = r_valid;
    assign bus.out_illegal = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Scoreboard bench for imm_decode_stage with a table-driven
//               reference model, directed cases and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;
    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  loc;
        logic        sgn;
        logic        vld;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t state;

    int locTab[32];
    int sgnTab[32];
    int illTab[32];

    imm_decode_stage_if #(.WIDTH(16)) bus ();

    imm_decode_stage #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic setOp(input int op, input int loc, input int sgn);
        locTab[op] = loc;
        sgnTab[op] = sgn;
        illTab[op] = 0;
    endtask

    // Decode table written straight from the opcode list.
    task automatic buildTable();
        for (int i = 0; i < 32; i++) begin
            locTab[i] = 3; sgnTab[i] = 0; illTab[i] = 1;
        end
        setOp(5'b01000, 0, 1); setOp(5'b01001, 0, 1);
        setOp(5'b01010, 0, 0); setOp(5'b01011, 0, 0);
        for (int i = 5'b10100; i <= 5'b10111; i++) setOp(i, 0, 0);
        setOp(5'b10000, 0, 1); setOp(5'b10001, 0, 1); setOp(5'b10011, 0, 1);
        for (int i = 5'b01100; i <= 5'b01111; i++) setOp(i, 1, 1);
        setOp(5'b11000, 1, 1);
        setOp(5'b10010, 1, 0);
        setOp(5'b00101, 1, 1); setOp(5'b00111, 1, 1);
        setOp(5'b00100, 2, 1); setOp(5'b00110, 2, 1);
        setOp(5'b00000, 3, 0); setOp(5'b00001, 3, 0);
        for (int i = 5'b11001; i <= 5'b11111; i++) setOp(i, 3, 0);
    endtask

    function automatic exp_t clearedState();
        exp_t e;
        e.imm = 16'h0000; e.loc = 2'b11; e.sgn = 1'b0; e.vld = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    // Value loaded for one instruction, computed with integer arithmetic.
    function automatic exp_t loadState(input logic [15:0] instr, input logic v);
        exp_t e;
        int   op;
        int   w;
        int   val;
        e = clearedState();
        if (!v) return e;
        op    = int'(instr[15:11]);
        e.loc = 2'(locTab[op]);
        e.sgn = 1'(sgnTab[op]);
        e.ill = 1'(illTab[op]);
        e.vld = 1'b1;
        if (locTab[op] != 3) begin
            w   = (locTab[op] == 0) ? 5 : (locTab[op] == 1) ? 8 : 11;
            val = int'(instr) % (1 << w);
            if (sgnTab[op] != 0 && val >= (1 << (w - 1))) val = val - (1 << w);
            e.imm = val[15:0];
        end
        return e;
    endfunction

    // Drive one cycle, advance the model at the edge and queue its result.
    task automatic cycle(input logic r, input logic [15:0] instr, input logic v,
                         input logic st, input logic fl);
        rst          = r;
        bus.in_instr = instr;
        bus.in_valid = v;
        bus.stall    = st;
        bus.flush    = fl;
        @(posedge clk);
        if (r || fl)  state = clearedState();
        else if (!st) state = loadState(instr, v);
        q.push_back(state);
        #1;
    endtask

    // Monitor: one registered output per edge, checked mid-cycle.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a.imm = bus.out_imm;
                a.loc = bus.out_imm_loc;
                a.sgn = bus.out_signed;
                a.vld = bus.out_valid;
                a.ill = bus.out_illegal;
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs @%0t: got imm=%h loc=%b sgn=%b vld=%b ill=%b, expected imm=%h loc=%b sgn=%b vld=%b ill=%b",
                             $time, a.imm, a.loc, a.sgn, a.vld, a.ill,
                             e.imm, e.loc, e.sgn, e.vld, e.ill);
                end
            end
        end
    end

    initial begin
        int budget;
        logic [15:0] ins;
        buildTable();
        state        = clearedState();
        bus.in_instr = 16'h0000;
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;

        // Reset
        cycle(1, 16'h0000, 0, 0, 0);
        cycle(1, 16'h401E, 1, 0, 0);
        // Extension cases
        cycle(0, 16'h401E, 1, 0, 0);   // ADDI -> FFFE
        cycle(0, 16'h501E, 1, 0, 0);   // XORI -> 001E
        cycle(0, 16'hC080, 1, 0, 0);   // LBI  -> FF80
        cycle(0, 16'h9080, 1, 0, 0);   // SLBI -> 0080
        cycle(0, 16'h2400, 1, 0, 0);   // J    -> FC00
        // Stall hold then release
        cycle(0, 16'h401E, 1, 0, 0);
        repeat (3) cycle(0, 16'hC080, 1, 1, 0);
        cycle(0, 16'hC080, 1, 0, 0);
        // Flush beats stall
        cycle(0, 16'h401E, 1, 0, 0);
        cycle(0, 16'hC080, 1, 1, 1);
        // Reset during stall
        cycle(0, 16'h401E, 1, 0, 0);
        cycle(0, 16'h401E, 1, 1, 0);
        cycle(1, 16'h401E, 1, 1, 0);
        // Bubble, illegal, HALT
        cycle(0, 16'h401E, 0, 0, 0);
        cycle(0, 16'h1000, 1, 0, 0);
        cycle(0, 16'h1800, 1, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);
        // Long stall holding an illegal opcode
        cycle(0, 16'h1000, 1, 0, 0);
        repeat (20) cycle(0, 16'h2400, 1, 1, 0);
        cycle(0, 16'hFFFF, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ins = 16'($urandom);
            cycle(($urandom_range(0, 99) < 2),
                  ins,
                  ($urandom_range(0, 99) < 80),
                  ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 5));
        end
        cycle(0, 16'h0000, 0, 0, 0);

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
